axi4_arb2: RTL and testbench



---
 rtl/axi4_arb2.sv | 208 ++++++++++++++++++++
 tb/tb_axi4_arb2.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_arb2.sv
// rtl/axi4_arb2.sv - two-master AXI4 arbiter onto one DDR inport, one burst per grant per direction.
// Define AXI_ARB_FIXED_PRIO_EN for fixed m0 priority; default is round-robin.
module axi4_arb2 #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              m0_awvalid_i,
    input  logic [ADDR_W-1:0] m0_awaddr_i,
    input  logic [ID_W-1:0]   m0_awid_i,
    input  logic [7:0]        m0_awlen_i,
    input  logic [1:0]        m0_awburst_i,
    output logic              m0_awready_o,
    input  logic              m0_wvalid_i,
    input  logic [31:0]       m0_wdata_i,
    input  logic [3:0]        m0_wstrb_i,
    input  logic              m0_wlast_i,
    output logic              m0_wready_o,
    output logic              m0_bvalid_o,
    output logic [1:0]        m0_bresp_o,
    output logic [ID_W-1:0]   m0_bid_o,
    input  logic              m0_bready_i,
    input  logic              m0_arvalid_i,
    input  logic [ADDR_W-1:0] m0_araddr_i,
    input  logic [ID_W-1:0]   m0_arid_i,
    input  logic [7:0]        m0_arlen_i,
    input  logic [1:0]        m0_arburst_i,
    output logic              m0_arready_o,
    output logic              m0_rvalid_o,
    output logic [31:0]       m0_rdata_o,
    output logic [1:0]        m0_rresp_o,
    output logic [ID_W-1:0]   m0_rid_o,
    output logic              m0_rlast_o,
    input  logic              m0_rready_i,
    input  logic              m1_awvalid_i,
    input  logic [ADDR_W-1:0] m1_awaddr_i,
    input  logic [ID_W-1:0]   m1_awid_i,
    input  logic [7:0]        m1_awlen_i,
    input  logic [1:0]        m1_awburst_i,
    output logic              m1_awready_o,
    input  logic              m1_wvalid_i,
    input  logic [31:0]       m1_wdata_i,
    input  logic [3:0]        m1_wstrb_i,
    input  logic              m1_wlast_i,
    output logic              m1_wready_o,
    output logic              m1_bvalid_o,
    output logic [1:0]        m1_bresp_o,
    output logic [ID_W-1:0]   m1_bid_o,
    input  logic              m1_bready_i,
    input  logic              m1_arvalid_i,
    input  logic [ADDR_W-1:0] m1_araddr_i,
    input  logic [ID_W-1:0]   m1_arid_i,
    input  logic [7:0]        m1_arlen_i,
    input  logic [1:0]        m1_arburst_i,
    output logic              m1_arready_o,
    output logic              m1_rvalid_o,
    output logic [31:0]       m1_rdata_o,
    output logic [1:0]        m1_rresp_o,
    output logic [ID_W-1:0]   m1_rid_o,
    output logic              m1_rlast_o,
    input  logic              m1_rready_i,
    output logic              s_awvalid_o,
    output logic [ADDR_W-1:0] s_awaddr_o,
    output logic [ID_W-1:0]   s_awid_o,
    output logic [7:0]        s_awlen_o,
    output logic [1:0]        s_awburst_o,
    input  logic              s_awready_i,
    output logic              s_wvalid_o,
    output logic [31:0]       s_wdata_o,
    output logic [3:0]        s_wstrb_o,
    output logic              s_wlast_o,
    input  logic              s_wready_i,
    input  logic              s_bvalid_i,
    input  logic [1:0]        s_bresp_i,
    input  logic [ID_W-1:0]   s_bid_i,
    output logic              s_bready_o,
    output logic              s_arvalid_o,
    output logic [ADDR_W-1:0] s_araddr_o,
    output logic [ID_W-1:0]   s_arid_o,
    output logic [7:0]        s_arlen_o,
    output logic [1:0]        s_arburst_o,
    input  logic              s_arready_i,
    input  logic              s_rvalid_i,
    input  logic [31:0]       s_rdata_i,
    input  logic [1:0]        s_rresp_i,
    input  logic [ID_W-1:0]   s_rid_i,
    input  logic              s_rlast_i,
    output logic              s_rready_o
);

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

    wstate_t wstate, wstate_nxt;
    rstate_t rstate, rstate_nxt;
    logic    wgnt, rgnt, wpick, rpick, w_start, r_start;
    logic    aw_on, w_on, b_on, ar_on, r_on;

    assign w_start = (wstate == W_IDLE) && (m0_awvalid_i || m1_awvalid_i);
    assign r_start = (rstate == R_IDLE) && (m0_arvalid_i || m1_arvalid_i);

`ifdef AXI_ARB_FIXED_PRIO_EN
    assign wpick = ~m0_awvalid_i;
    assign rpick = ~m0_arvalid_i;
`else
    // Last-granted bits reset to 1 so that m0 wins the first contention.
    logic wlast_gnt, rlast_gnt;
    assign wpick = (m0_awvalid_i && m1_awvalid_i) ? ~wlast_gnt : m1_awvalid_i;
    assign rpick = (m0_arvalid_i && m1_arvalid_i) ? ~rlast_gnt : m1_arvalid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wlast_gnt <= 1'b1;
            rlast_gnt <= 1'b1;
        end else begin
            if (w_start) wlast_gnt <= wpick;
            if (r_start) rlast_gnt <= rpick;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wstate <= W_IDLE;
            rstate <= R_IDLE;
            wgnt   <= 1'b0;
            rgnt   <= 1'b0;
        end else begin
            wstate <= wstate_nxt;
            rstate <= rstate_nxt;
            if (w_start) wgnt <= wpick;
            if (r_start) rgnt <= rpick;
        end
    end

    always_comb begin
        wstate_nxt = wstate;
        case (wstate)
            W_IDLE:  if (w_start) wstate_nxt = W_ADDR;
            W_ADDR:  if (s_awvalid_o && s_awready_i) wstate_nxt = W_DATA;
            W_DATA:  if (s_wvalid_o && s_wready_i && s_wlast_o) wstate_nxt = W_RESP;
            W_RESP:  if (s_bvalid_i && s_bready_o) wstate_nxt = W_IDLE;
            default: wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_nxt = rstate;
        case (rstate)
            R_IDLE:  if (r_start) rstate_nxt = R_ADDR;
            R_ADDR:  if (s_arvalid_o && s_arready_i) rstate_nxt = R_DATA;
            R_DATA:  if (s_rvalid_i && s_rready_o && s_rlast_i) rstate_nxt = R_IDLE;
            default: rstate_nxt = R_IDLE;
        endcase
    end

    assign aw_on = (wstate == W_ADDR);
    assign w_on  = (wstate == W_DATA);
    assign b_on  = (wstate == W_RESP);
    assign ar_on = (rstate == R_ADDR);
    assign r_on  = (rstate == R_DATA);

    // Payloads are zeroed outside the active phase so idle and reset outputs are clean.
    assign s_awvalid_o  = aw_on & (wgnt ? m1_awvalid_i : m0_awvalid_i);
    assign s_awaddr_o   = aw_on ? (wgnt ? m1_awaddr_i  : m0_awaddr_i)  : '0;
    assign s_awid_o     = aw_on ? (wgnt ? m1_awid_i    : m0_awid_i)    : '0;
    assign s_awlen_o    = aw_on ? (wgnt ? m1_awlen_i   : m0_awlen_i)   : '0;
    assign s_awburst_o  = aw_on ? (wgnt ? m1_awburst_i : m0_awburst_i) : '0;
    assign m0_awready_o = aw_on & ~wgnt & s_awready_i;
    assign m1_awready_o = aw_on &  wgnt & s_awready_i;

    assign s_wvalid_o   = w_on & (wgnt ? m1_wvalid_i : m0_wvalid_i);
    assign s_wdata_o    = w_on ? (wgnt ? m1_wdata_i : m0_wdata_i) : '0;
    assign s_wstrb_o    = w_on ? (wgnt ? m1_wstrb_i : m0_wstrb_i) : '0;
    assign s_wlast_o    = w_on & (wgnt ? m1_wlast_i : m0_wlast_i);
    assign m0_wready_o  = w_on & ~wgnt & s_wready_i;
    assign m1_wready_o  = w_on &  wgnt & s_wready_i;

    assign s_bready_o   = b_on & (wgnt ? m1_bready_i : m0_bready_i);
    assign m0_bvalid_o  = b_on & ~wgnt & s_bvalid_i;
    assign m1_bvalid_o  = b_on &  wgnt & s_bvalid_i;
    assign m0_bresp_o   = (b_on & ~wgnt) ? s_bresp_i : '0;
    assign m1_bresp_o   = (b_on &  wgnt) ? s_bresp_i : '0;
    assign m0_bid_o     = (b_on & ~wgnt) ? s_bid_i   : '0;
    assign m1_bid_o     = (b_on &  wgnt) ? s_bid_i   : '0;

    assign s_arvalid_o  = ar_on & (rgnt ? m1_arvalid_i : m0_arvalid_i);
    assign s_araddr_o   = ar_on ? (rgnt ? m1_araddr_i  : m0_araddr_i)  : '0;
    assign s_arid_o     = ar_on ? (rgnt ? m1_arid_i    : m0_arid_i)    : '0;
    assign s_arlen_o    = ar_on ? (rgnt ? m1_arlen_i   : m0_arlen_i)   : '0;
    assign s_arburst_o  = ar_on ? (rgnt ? m1_arburst_i : m0_arburst_i) : '0;
    assign m0_arready_o = ar_on & ~rgnt & s_arready_i;
    assign m1_arready_o = ar_on &  rgnt & s_arready_i;

    assign s_rready_o   = r_on & (rgnt ? m1_rready_i : m0_rready_i);
    assign m0_rvalid_o  = r_on & ~rgnt & s_rvalid_i;
    assign m1_rvalid_o  = r_on &  rgnt & s_rvalid_i;
    assign m0_rlast_o   = r_on & ~rgnt & s_rlast_i;
    assign m1_rlast_o   = r_on &  rgnt & s_rlast_i;
    assign m0_rdata_o   = (r_on & ~rgnt) ? s_rdata_i : '0;
    assign m1_rdata_o   = (r_on &  rgnt) ? s_rdata_i : '0;
    assign m0_rresp_o   = (r_on & ~rgnt) ? s_rresp_i : '0;
    assign m1_rresp_o   = (r_on &  rgnt) ? s_rresp_i : '0;
    assign m0_rid_o     = (r_on & ~rgnt) ? s_rid_i   : '0;
    assign m1_rid_o     = (r_on &  rgnt) ? s_rid_i   : '0;

endmodule

// File: tb/tb_axi4_arb2.sv
// tb/tb_axi4_arb2.sv - directed self-checking bench for axi4_arb2.
module tb_axi4_arb2;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic m0_awvalid_i, m1_awvalid_i, m0_wvalid_i, m1_wvalid_i, m0_wlast_i, m1_wlast_i;
    logic m0_bready_i, m1_bready_i, m0_arvalid_i, m1_arvalid_i, m0_rready_i, m1_rready_i;
    logic [31:0] m0_awaddr_i, m1_awaddr_i, m0_araddr_i, m1_araddr_i, m0_wdata_i, m1_wdata_i;
    logic [3:0]  m0_awid_i, m1_awid_i, m0_arid_i, m1_arid_i, m0_wstrb_i, m1_wstrb_i;
    logic [7:0]  m0_awlen_i, m1_awlen_i, m0_arlen_i, m1_arlen_i;
    logic [1:0]  m0_awburst_i, m1_awburst_i, m0_arburst_i, m1_arburst_i;
    logic m0_awready_o, m1_awready_o, m0_wready_o, m1_wready_o, m0_bvalid_o, m1_bvalid_o;
    logic m0_arready_o, m1_arready_o, m0_rvalid_o, m1_rvalid_o, m0_rlast_o, m1_rlast_o;
    logic [1:0]  m0_bresp_o, m1_bresp_o, m0_rresp_o, m1_rresp_o;
    logic [3:0]  m0_bid_o, m1_bid_o, m0_rid_o, m1_rid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic s_awvalid_o, s_wvalid_o, s_wlast_o, s_bready_o, s_arvalid_o, s_rready_o;
    logic [31:0] s_awaddr_o, s_araddr_o, s_wdata_o;
    logic [3:0]  s_awid_o, s_arid_o, s_wstrb_o;
    logic [7:0]  s_awlen_o, s_arlen_o;
    logic [1:0]  s_awburst_o, s_arburst_o;
    logic s_awready_i, s_wready_i, s_bvalid_i, s_arready_i, s_rvalid_i, s_rlast_i;
    logic [1:0]  s_bresp_i, s_rresp_i;
    logic [3:0]  s_bid_i, s_rid_i;
    logic [31:0] s_rdata_i;

    int n_checks = 0;
    int n_err    = 0;

    logic [14:0]  ctl_out;
    logic [171:0] pay_out;
    assign ctl_out = {m0_awready_o, m1_awready_o, m0_wready_o, m1_wready_o, m0_bvalid_o,
                      m1_bvalid_o, m0_arready_o, m1_arready_o, m0_rvalid_o, m1_rvalid_o,
                      s_awvalid_o, s_wvalid_o, s_bready_o, s_arvalid_o, s_rready_o};
    assign pay_out = {s_awaddr_o, s_wdata_o, s_araddr_o, m0_rdata_o, m1_rdata_o, s_awlen_o, m0_bid_o};

    axi4_arb2 #(.ID_W(4), .ADDR_W(32)) dut (
        .clk_i, .rst_ni,
        .m0_awvalid_i, .m0_awaddr_i, .m0_awid_i, .m0_awlen_i, .m0_awburst_i, .m0_awready_o,
        .m0_wvalid_i, .m0_wdata_i, .m0_wstrb_i, .m0_wlast_i, .m0_wready_o,
        .m0_bvalid_o, .m0_bresp_o, .m0_bid_o, .m0_bready_i,
        .m0_arvalid_i, .m0_araddr_i, .m0_arid_i, .m0_arlen_i, .m0_arburst_i, .m0_arready_o,
        .m0_rvalid_o, .m0_rdata_o, .m0_rresp_o, .m0_rid_o, .m0_rlast_o, .m0_rready_i,
        .m1_awvalid_i, .m1_awaddr_i, .m1_awid_i, .m1_awlen_i, .m1_awburst_i, .m1_awready_o,
        .m1_wvalid_i, .m1_wdata_i, .m1_wstrb_i, .m1_wlast_i, .m1_wready_o,
        .m1_bvalid_o, .m1_bresp_o, .m1_bid_o, .m1_bready_i,
        .m1_arvalid_i, .m1_araddr_i, .m1_arid_i, .m1_arlen_i, .m1_arburst_i, .m1_arready_o,
        .m1_rvalid_o, .m1_rdata_o, .m1_rresp_o, .m1_rid_o, .m1_rlast_o, .m1_rready_i,
        .s_awvalid_o, .s_awaddr_o, .s_awid_o, .s_awlen_o, .s_awburst_o, .s_awready_i,
        .s_wvalid_o, .s_wdata_o, .s_wstrb_o, .s_wlast_o, .s_wready_i,
        .s_bvalid_i, .s_bresp_i, .s_bid_i, .s_bready_o,
        .s_arvalid_o, .s_araddr_o, .s_arid_o, .s_arlen_o, .s_arburst_o, .s_arready_i,
        .s_rvalid_i, .s_rdata_i, .s_rresp_i, .s_rid_i, .s_rlast_i, .s_rready_o
    );

    always #5 clk_i = ~clk_i;

    task automatic clear_inputs;
        {m0_awvalid_i, m1_awvalid_i, m0_wvalid_i, m1_wvalid_i, m0_wlast_i, m1_wlast_i} = '0;
        {m0_bready_i, m1_bready_i, m0_arvalid_i, m1_arvalid_i, m0_rready_i, m1_rready_i} = '0;
        {m0_awaddr_i, m1_awaddr_i, m0_araddr_i, m1_araddr_i, m0_wdata_i, m1_wdata_i} = '0;
        {m0_awid_i, m1_awid_i, m0_arid_i, m1_arid_i, m0_wstrb_i, m1_wstrb_i} = '0;
        {m0_awlen_i, m1_awlen_i, m0_arlen_i, m1_arlen_i} = '0;
        {m0_awburst_i, m1_awburst_i, m0_arburst_i, m1_arburst_i} = '0;
        {s_awready_i, s_wready_i, s_bvalid_i, s_arready_i, s_rvalid_i, s_rlast_i} = '0;
        {s_bresp_i, s_rresp_i, s_bid_i, s_rid_i, s_rdata_i} = '0;
    endtask

    task automatic do_reset;
        rst_ni = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        clear_inputs();
        m0_awvalid_i = 1; m1_arvalid_i = 1; s_awready_i = 1; s_wready_i = 1;
        s_bvalid_i = 1; s_rvalid_i = 1; s_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk_i); #1;
        n_checks++;
        if (ctl_out !== 15'h0) begin n_err++; $display("FAIL reset_ctl got=%h exp=0", ctl_out); end
        n_checks++;
        if (pay_out !== '0) begin n_err++; $display("FAIL reset_payload got=%h exp=0", pay_out); end
        rst_ni = 1'b1;
        @(negedge clk_i); #1;
        n_checks++;
        if ({s_awvalid_o, s_arvalid_o, m0_awready_o, m1_arready_o} !== 4'b1110) begin
            n_err++; $display("FAIL first_grant got=%b exp=1110", {s_awvalid_o, s_arvalid_o, m0_awready_o, m1_arready_o});
        end
    endtask

    task automatic test_single_write;
        logic m1_seen;
        int beats;
        logic [31:0] exp_d;
        do_reset();
        m1_seen = 0; beats = 0;
        @(negedge clk_i);
        m0_awvalid_i = 1; m0_awaddr_i = 32'h0000_1000; m0_awid_i = 4'h5; m0_awlen_i = 8'd3; m0_awburst_i = 2'b01;
        #1;
        n_checks++;
        if (s_awvalid_o !== 1'b0) begin n_err++; $display("FAIL wr_idle_cycle got=%b exp=0", s_awvalid_o); end
        @(negedge clk_i); s_awready_i = 1; #1;
        m1_seen |= m1_awready_o;
        n_checks++;
        if ({s_awvalid_o, m0_awready_o, m1_awready_o} !== 3'b110) begin
            n_err++; $display("FAIL wr_aw_route got=%b exp=110", {s_awvalid_o, m0_awready_o, m1_awready_o});
        end
        n_checks++;
        if ({s_awaddr_o, s_awid_o, s_awlen_o, s_awburst_o} !== {32'h0000_1000, 4'h5, 8'd3, 2'b01}) begin
            n_err++; $display("FAIL wr_aw_payload got=%h/%h/%h exp=1000/5/3", s_awaddr_o, s_awid_o, s_awlen_o);
        end
        @(negedge clk_i); m0_awvalid_i = 0; s_awready_i = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk_i);
            exp_d = 32'h11 * (i + 1);
            m0_wvalid_i = 1; m0_wdata_i = exp_d; m0_wstrb_i = 4'hF; m0_wlast_i = (i == 3); s_wready_i = 1;
            #1;
            m1_seen |= m1_awready_o | m1_wready_o;
            if (s_wvalid_o && s_wready_i) beats++;
            n_checks++;
            if ({s_wdata_o, s_wlast_o, m0_wready_o} !== {exp_d, (i == 3), 1'b1}) begin
                n_err++; $display("FAIL wr_beat%0d got=%h last=%b exp=%h", i, s_wdata_o, s_wlast_o, exp_d);
            end
        end
        @(negedge clk_i);
        m0_wvalid_i = 0; m0_wlast_i = 0; s_wready_i = 0;
        s_bvalid_i = 1; s_bid_i = 4'h5; s_bresp_i = 2'b01; m0_bready_i = 1;
        #1;
        m1_seen |= m1_awready_o | m1_bvalid_o;
        n_checks++;
        if ({m0_bvalid_o, m1_bvalid_o, s_bready_o, m0_bid_o, m0_bresp_o} !== {3'b101, 4'h5, 2'b01}) begin
            n_err++; $display("FAIL wr_b_route got=%b%b%b id=%h exp=101 id=5", m0_bvalid_o, m1_bvalid_o, s_bready_o, m0_bid_o);
        end
        @(negedge clk_i); s_bvalid_i = 0; m0_bready_i = 0; #1;
        n_checks++;
        if ({s_bready_o, s_awvalid_o, beats[3:0], m1_seen} !== {2'b00, 4'd4, 1'b0}) begin
            n_err++; $display("FAIL wr_summary beats=%0d m1_seen=%b exp beats=4 m1_seen=0", beats, m1_seen);
        end
    endtask

    task automatic test_read_contention;
        logic [31:0] exp_a;
        do_reset();
        @(negedge clk_i);
        m0_arvalid_i = 1; m0_araddr_i = 32'hA000; m0_arid_i = 4'h1;
        m1_arvalid_i = 1; m1_araddr_i = 32'hB000; m1_arid_i = 4'h2;
        @(negedge clk_i); s_arready_i = 1; #1;
        n_checks++;
        if ({s_arvalid_o, m0_arready_o, m1_arready_o, s_araddr_o, s_arid_o} !== {3'b110, 32'hA000, 4'h1}) begin
            n_err++; $display("FAIL rd_first_m0 got=%b%b%b addr=%h exp=110 addr=a000", s_arvalid_o, m0_arready_o, m1_arready_o, s_araddr_o);
        end
        @(negedge clk_i);
        m0_arvalid_i = 0; s_arready_i = 0;
        s_rvalid_i = 1; s_rdata_i = 32'hCAFE_0001; s_rid_i = 4'h1; s_rlast_i = 1; m0_rready_i = 1;
        #1;
        n_checks++;
        if ({m0_rvalid_o, m1_rvalid_o, s_rready_o, m0_rlast_o, m0_rdata_o, m0_rid_o} !== {4'b1011, 32'hCAFE_0001, 4'h1}) begin
            n_err++; $display("FAIL rd_r_route got=%b%b data=%h exp=10 data=cafe0001", m0_rvalid_o, m1_rvalid_o, m0_rdata_o);
        end
        @(negedge clk_i);
        s_rvalid_i = 0; s_rlast_i = 0; m0_rready_i = 0;
        m0_arvalid_i = 1; m0_araddr_i = 32'hC000; m0_arid_i = 4'h3;
        #1;
        n_checks++;
        if (s_arvalid_o !== 1'b0) begin n_err++; $display("FAIL rd_idle_gap got=%b exp=0", s_arvalid_o); end
`ifdef AXI_ARB_FIXED_PRIO_EN
        exp_a = 32'hC000;
`else
        exp_a = 32'hB000;
`endif
        @(negedge clk_i); #1;
        n_checks++;
        if ({s_arvalid_o, s_araddr_o} !== {1'b1, exp_a}) begin
            n_err++; $display("FAIL rd_second_grant got=%b addr=%h exp=1 addr=%h", s_arvalid_o, s_araddr_o, exp_a);
        end
    endtask

    task automatic test_concurrent;
        do_reset();
        @(negedge clk_i);
        m0_arvalid_i = 1; m0_araddr_i = 32'h2000; m0_arid_i = 4'h3; m0_arlen_i = 8'd7; m0_arburst_i = 2'b01;
        m1_awvalid_i = 1; m1_awaddr_i = 32'h3000; m1_awid_i = 4'h9; m1_awlen_i = 8'd0; m1_awburst_i = 2'b01;
        @(negedge clk_i); s_arready_i = 1; s_awready_i = 1; #1;
        n_checks++;
        if ({s_arvalid_o, s_awvalid_o, m0_arready_o, m1_arready_o, m0_awready_o, m1_awready_o} !== 6'b111001) begin
            n_err++; $display("FAIL cc_addr_route got=%b exp=111001",
                {s_arvalid_o, s_awvalid_o, m0_arready_o, m1_arready_o, m0_awready_o, m1_awready_o});
        end
        n_checks++;
        if ({s_awid_o, s_arid_o, s_arlen_o, s_awlen_o} !== {4'h9, 4'h3, 8'd7, 8'd0}) begin
            n_err++; $display("FAIL cc_addr_ids got=%h/%h/%h/%h exp=9/3/07/00", s_awid_o, s_arid_o, s_arlen_o, s_awlen_o);
        end
        @(negedge clk_i);
        m0_arvalid_i = 0; m1_awvalid_i = 0; s_arready_i = 0; s_awready_i = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk_i);
            s_rvalid_i = 1; s_rdata_i = 32'hD000_0000 + i; s_rid_i = 4'h3; s_rlast_i = (i == 7); m0_rready_i = 1;
            m1_wvalid_i = (i == 0); m1_wdata_i = 32'hABCD; m1_wlast_i = (i == 0); s_wready_i = (i == 0);
            s_bvalid_i = (i == 1); s_bid_i = 4'h9; m1_bready_i = (i == 1);
            #1;
            n_checks++;
            if ({m0_rvalid_o, m1_rvalid_o, m0_rdata_o} !== {2'b10, 32'hD000_0000 + i}) begin
                n_err++; $display("FAIL cc_rbeat%0d got=%b%b data=%h", i, m0_rvalid_o, m1_rvalid_o, m0_rdata_o);
            end
            if (i == 0) begin
                n_checks++;
                if ({s_wvalid_o, m1_wready_o, m0_wready_o, s_rready_o, s_wdata_o} !== {4'b1101, 32'hABCD}) begin
                    n_err++; $display("FAIL cc_w_overlap got=%b%b%b%b data=%h exp=1101 abcd",
                        s_wvalid_o, m1_wready_o, m0_wready_o, s_rready_o, s_wdata_o);
                end
            end
            if (i == 1) begin
                n_checks++;
                if ({m1_bvalid_o, m0_bvalid_o, m1_bid_o} !== {2'b10, 4'h9}) begin
                    n_err++; $display("FAIL cc_b_m1 got=%b%b id=%h exp=10 id=9", m1_bvalid_o, m0_bvalid_o, m1_bid_o);
                end
            end
        end
        @(negedge clk_i); clear_inputs(); #1;
        n_checks++;
        if (ctl_out !== 15'h0) begin n_err++; $display("FAIL cc_idle got=%h exp=0", ctl_out); end
    endtask

    task automatic test_stalls;
        int got;
        int rgot;
        do_reset();
        got = 0; rgot = 0;
        @(negedge clk_i);
        m0_awvalid_i = 1; m0_awaddr_i = 32'h4000; m0_awid_i = 4'h1; m0_awlen_i = 8'd7; s_awready_i = 1;
        @(negedge clk_i);
        @(negedge clk_i); m0_awvalid_i = 0; s_awready_i = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            if (cyc > 0) @(negedge clk_i);
            m0_wvalid_i = 1; m0_wdata_i = 32'h5500_0000 + got; m0_wlast_i = (got == 7);
            s_wready_i = !(cyc >= 3 && cyc < 8);
            #1;
            n_checks++;
            if (m0_wready_o !== s_wready_i) begin
                n_err++; $display("FAIL st_wready_follow cyc=%0d got=%b exp=%b", cyc, m0_wready_o, s_wready_i);
            end
            if (s_wvalid_o && s_wready_i) begin
                n_checks++;
                if (s_wdata_o !== 32'h5500_0000 + got) begin
                    n_err++; $display("FAIL st_w_order got=%h exp=%h", s_wdata_o, 32'h5500_0000 + got);
                end
                got++;
            end
        end
        @(negedge clk_i); m0_wlast_i = 0; s_wready_i = 1; #1;
        n_checks++;
        if ({got[3:0], s_wvalid_o, m0_wready_o} !== {4'd8, 2'b00}) begin
            n_err++; $display("FAIL st_w_count beats=%0d extra=%b%b exp beats=8 extra=00", got, s_wvalid_o, m0_wready_o);
        end
        m0_wvalid_i = 0; s_wready_i = 0; s_bvalid_i = 1; m0_bready_i = 1;
        @(negedge clk_i); clear_inputs();
        m1_arvalid_i = 1; m1_araddr_i = 32'h6000; m1_arid_i = 4'h6; m1_arlen_i = 8'd3; s_arready_i = 1;
        @(negedge clk_i);
        @(negedge clk_i); m1_arvalid_i = 0; s_arready_i = 0;
        for (int cyc = 0; cyc < 30 && rgot < 4; cyc++) begin
            if (cyc > 0) @(negedge clk_i);
            s_rvalid_i = (cyc % 2 == 0); s_rdata_i = 32'h7700_0000 + rgot; s_rlast_i = (rgot == 3); m1_rready_i = 1;
            #1;
            n_checks++;
            if (m1_rvalid_o !== s_rvalid_i) begin
                n_err++; $display("FAIL st_rvalid_follow cyc=%0d got=%b exp=%b", cyc, m1_rvalid_o, s_rvalid_i);
            end
            if (m1_rvalid_o && m1_rready_i) begin
                n_checks++;
                if (m1_rdata_o !== 32'h7700_0000 + rgot) begin
                    n_err++; $display("FAIL st_r_order got=%h exp=%h", m1_rdata_o, 32'h7700_0000 + rgot);
                end
                rgot++;
            end
        end
        @(negedge clk_i); s_rvalid_i = 1; s_rlast_i = 0; #1;
        n_checks++;
        if ({rgot[3:0], m1_rvalid_o, m0_rvalid_o} !== {4'd4, 2'b00}) begin
            n_err++; $display("FAIL st_r_count beats=%0d extra=%b exp beats=4 extra=0", rgot, m1_rvalid_o);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_burst;
        do_reset();
        @(negedge clk_i);
        m0_awvalid_i = 1; m0_awaddr_i = 32'h8000; m0_awlen_i = 8'd3; s_awready_i = 1;
        @(negedge clk_i);
        @(negedge clk_i);
        m0_awvalid_i = 0; s_awready_i = 0; m0_wvalid_i = 1; m0_wdata_i = 32'h1; s_wready_i = 1;
        @(negedge clk_i); m0_wdata_i = 32'h2; #1;
        n_checks++;
        if ({s_wvalid_o, s_wdata_o} !== {1'b1, 32'h2}) begin
            n_err++; $display("FAIL rm_beat2 got=%b data=%h exp=1 data=2", s_wvalid_o, s_wdata_o);
        end
        rst_ni = 1'b0; #1;
        n_checks++;
        if ({ctl_out, pay_out} !== '0) begin
            n_err++; $display("FAIL rm_async_clear ctl=%h pay=%h exp=0", ctl_out, pay_out);
        end
        @(negedge clk_i); clear_inputs();
        @(negedge clk_i); rst_ni = 1'b1;
        @(negedge clk_i);
        m1_awvalid_i = 1; m1_awaddr_i = 32'h9000; m1_awid_i = 4'h7; m1_awlen_i = 8'd1; s_awready_i = 1;
        @(negedge clk_i); #1;
        n_checks++;
        if ({s_awvalid_o, m1_awready_o, m0_awready_o, s_awaddr_o} !== {3'b110, 32'h9000}) begin
            n_err++; $display("FAIL rm_m1_aw got=%b%b%b addr=%h exp=110 addr=9000", s_awvalid_o, m1_awready_o, m0_awready_o, s_awaddr_o);
        end
        @(negedge clk_i); m1_awvalid_i = 0; s_awready_i = 0;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk_i);
            m1_wvalid_i = 1; m1_wdata_i = 32'hE0 + i; m1_wlast_i = (i == 1); s_wready_i = 1;
            #1;
            n_checks++;
            if ({s_wvalid_o, m1_wready_o, s_wlast_o, s_wdata_o} !== {2'b11, (i == 1), 32'hE0 + i}) begin
                n_err++; $display("FAIL rm_m1_beat%0d got=%b%b data=%h", i, s_wvalid_o, m1_wready_o, s_wdata_o);
            end
        end
        @(negedge clk_i);
        m1_wvalid_i = 0; m1_wlast_i = 0; s_wready_i = 0; s_bvalid_i = 1; s_bid_i = 4'h7; m1_bready_i = 1;
        #1;
        n_checks++;
        if ({m1_bvalid_o, m0_bvalid_o, m1_bid_o} !== {2'b10, 4'h7}) begin
            n_err++; $display("FAIL rm_m1_b got=%b%b id=%h exp=10 id=7", m1_bvalid_o, m0_bvalid_o, m1_bid_o);
        end
        @(negedge clk_i); clear_inputs(); #1;
        n_checks++;
        if (ctl_out !== 15'h0) begin n_err++; $display("FAIL rm_idle got=%h exp=0", ctl_out); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_contention();
        test_concurrent();
        test_stalls();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
